onehot_encode_serial: RTL and testbench

//   Inverse of the team's 3-to-8 one-hot decoder. Accepts an 8-bit request vector and emits the
//   3-bit binary index of every set bit, one per output beat, lowest index first.

---
 rtl/enc_pkg.sv | 14 +
 rtl/lsb_prio_enc.sv | 24 ++
 rtl/onehot_encode_serial.sv | 113 +++++++++++
 tb/tb_onehot_encode_serial.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared widths and FSM state encoding for the serial one-hot encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enc_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_OUT_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: vector -> index of lowest set bit plus any-set flag.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module lsb_prio_enc #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 3
) (
    input  logic [IN_W-1:0]  vec_i,
    output logic [OUT_W-1:0] idx_o,
    output logic             any_o
);

    // Scan from the top so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx_o = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = OUT_W'(i);
            end
        end
        any_o = |vec_i;
    end

endmodule

// File: rtl/onehot_encode_serial.sv
// Serialises an IN_W request vector into one index beat per set bit, lowest first.
// Latency: first beat valid the cycle after the vector is accepted; 1 beat/cycle.
// Backpressure: out_ready low holds the beat; in_ready only in IDLE or on an accepted last beat.
module onehot_encode_serial
    import enc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_code,
    output logic             out_last,
    output logic             out_zero
);

    state_t            state_q, state_d;
    logic [IN_W-1:0]   pending_q, pending_d;
    logic              zero_q, zero_d;

    logic [OUT_W-1:0]  low_idx;
    logic              any_set;
    logic              single_bit;
    logic              emit;
    logic              last_beat;
    logic              in_xfer;
    logic              out_xfer;
    logic [IN_W-1:0]   clr_mask;

    lsb_prio_enc #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_enc (
        .vec_i (pending_q),
        .idx_o (low_idx),
        .any_o (any_set)
    );

    // Exactly one bit left: clearing the lowest set bit leaves nothing behind.
    assign single_bit = any_set && ((pending_q & (pending_q - IN_W'(1))) == '0);
    assign emit       = (state_q == EMIT);
    assign last_beat  = emit && (zero_q || single_bit);

    // Outputs come only from registered state, never from in_vec/in_valid.
    assign out_valid  = emit;
    assign out_code   = emit ? low_idx : '0;
    assign out_last   = last_beat;
    assign out_zero   = emit && zero_q;

    // Ready is forced low during reset; the last-beat case lets a new vector follow with no bubble.
    assign in_ready   = rst_n && (!emit || (last_beat && out_ready));
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = emit && out_ready;

    assign clr_mask   = {{(IN_W-1){1'b0}}, 1'b1} << low_idx;

    // Next-state: load on input transfer, retire one bit per output transfer.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = zero_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    pending_d = in_vec;
                    zero_d    = (in_vec == '0);
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (out_xfer) begin
                    if (last_beat) begin
                        if (in_xfer) begin
                            pending_d = in_vec;
                            zero_d    = (in_vec == '0);
                            state_d   = EMIT;
                        end else begin
                            pending_d = '0;
                            zero_d    = 1'b0;
                            state_d   = IDLE;
                        end
                    end else begin
                        pending_d = pending_q & ~clr_mask;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
                zero_d    = 1'b0;
            end
        endcase
    end

    // State and pending-vector registers; reset discards any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_onehot_encode_serial.sv
// Bench for onehot_encode_serial: directed scenarios plus random vectors and random out_ready.
// Reference: a queue of expected {code,last,zero} beats built from each accepted vector.
// Inputs change 1 time unit after posedge; outputs are checked on negedge.
module tb_onehot_encode_serial;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_last;
    logic       out_zero;

    int n_chk = 0;
    int n_bad = 0;
    logic rnd_rdy = 1'b0;

    // Expected beats, front = beat currently due: {code[2:0], last, zero}
    logic [4:0] exp_q[$];

    onehot_encode_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Build the beat list for one vector from the rules: each set bit, ascending; zero -> one beat.
    task automatic push_beats(input logic [7:0] v);
        int k;
        int seen;
        logic [2:0] c;
        k = 0;
        for (int i = 0; i < 8; i++) k += v[i];
        if (k == 0) begin
            exp_q.push_back({3'd0, 1'b1, 1'b1});
        end else begin
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    seen++;
                    c = 3'(i);
                    exp_q.push_back({c, (seen == k), 1'b0});
                end
            end
        end
    endtask

    // Cycle checker: compare the DUT against the model, then advance the model for the next edge.
    initial begin
        logic [4:0] b;
        logic exp_irdy;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_out_code", out_code, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_out_zero", out_zero, 0);
            end else begin
                exp_irdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
                chk("in_ready", in_ready, exp_irdy);
                chk("out_valid", out_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    b = exp_q[0];
                    chk("out_code", out_code, b[4:2]);
                    chk("out_last", out_last, b[1]);
                    chk("out_zero", out_zero, b[0]);
                end
                if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (in_valid && in_ready) push_beats(in_vec);
            end
        end
    end

    // Random out_ready while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offer a vector and hold it until accepted; returns 1 unit after the accepting edge.
    task automatic send(input logic [7:0] v);
        int n;
        logic acc;
        in_vec   = v;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single bit, zero vector, multi-bit
        send(8'b0000_0100);
        drain();
        send(8'b1010_0011);
        drain();
        send(8'h00);
        drain();

        // First beat stalled for three cycles
        out_ready = 1'b0;
        send(8'b1000_0001);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Back-to-back single-bit vectors
        send(8'b0001_0000);
        send(8'b0000_0010);
        drain();

        // Reset in the middle of an 8-beat vector
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_no_residual", out_valid, 0);
        send(8'h08);
        drain();

        // Random vectors with random gaps and random out_ready
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 8'($urandom);
            send(v);
        end
        rnd_rdy = 1'b0;
        #1;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
